// File: rtl/dct_sched_pkg.sv
// Shared types and constants for the DCT job scheduler.
package dct_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CFG_Q    = 3'd1,
        CFG_SIZE = 3'd2,
        LOAD     = 3'd3,
        READ     = 3'd4
    } sched_state_t;

    localparam int ADDR_W  = 8;
    localparam int POWER_W = 3;
    localparam int M_W     = 5;

    // Engine register map
    localparam logic [ADDR_W-1:0] ADDR_START = 8'd0;
    localparam logic [ADDR_W-1:0] ADDR_DATA  = 8'd1;
    localparam logic [ADDR_W-1:0] ADDR_SETQ  = 8'd2;

    // Width of an index into n items, never less than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dct_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted requester.
module rr_arbiter
    import dct_sched_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] last_idx;
    logic             found;

    // Pick the first active request after last_idx, wrapping around
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!found && req[(int'(last_idx) + off) % NUM_REQ]) begin
                found = 1'b1;
                grant[(int'(last_idx) + off) % NUM_REQ] = 1'b1;
                grant_idx = IDX_W'((int'(last_idx) + off) % NUM_REQ);
            end
        end
    end

    // Remember the winner so the next search starts after it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_idx <= IDX_W'(NUM_REQ - 1);
        end else if (advance) begin
            last_idx <= grant_idx;
        end
    end

endmodule

// File: rtl/dct_job_scheduler.sv
// Shares one DCT engine between several requesters: arbitrate, configure,
// stream samples in, then read coefficients out through a one-entry buffer.
module dct_job_scheduler
    import dct_sched_pkg::*;
#(
    parameter  int MAX_SIZE = 64,
    parameter  int NBITS    = 16,
    parameter  int NUM_REQ  = 2,
    localparam int HEIGHT   = $clog2(MAX_SIZE),
    localparam int OWNER_W  = $clog2(NUM_REQ),
    localparam int SIZE_W   = HEIGHT + 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0]                jreq_valid,
    input  logic [NUM_REQ-1:0][POWER_W-1:0]   jreq_power,
    input  logic [NUM_REQ-1:0][M_W-1:0]       jreq_m,
    output logic [NUM_REQ-1:0]                jreq_ready,
    input  logic [NUM_REQ-1:0]                in_valid,
    input  logic [NUM_REQ-1:0][NBITS-1:0]     in_data,
    output logic [NUM_REQ-1:0]                in_ready,
    output logic                              out_valid,
    output logic [NBITS-1:0]                  out_data,
    output logic [HEIGHT-1:0]                 out_index,
    output logic [OWNER_W-1:0]                out_owner,
    output logic                              out_last,
    input  logic                              out_ready,
    output logic [ADDR_W-1:0]                 dct_address,
    output logic                              dct_write,
    output logic                              dct_read,
    output logic [NBITS-1:0]                  dct_writedata,
    input  logic [NBITS-1:0]                  dct_readdata,
    input  logic                              dct_done,
    output logic                              busy
);

    sched_state_t         state, next_state;
    logic [OWNER_W-1:0]   owner;
    logic [M_W-1:0]       m_q;
    logic [POWER_W-1:0]   p_q;
    logic [SIZE_W-1:0]    size_q;
    logic [SIZE_W-1:0]    cnt_q;

    logic [NUM_REQ-1:0]   grant;
    logic [OWNER_W-1:0]   grant_idx;
    logic                 handshake;
    logic [POWER_W-1:0]   power_sel;
    logic [POWER_W-1:0]   p_sat;
    logic                 load_fire;
    logic                 read_fire;
    logic                 at_last;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (jreq_valid),
        .advance   (handshake),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign handshake = (state == IDLE) && (|grant);
    assign power_sel = jreq_power[grant_idx];
    assign p_sat     = (int'(power_sel) > HEIGHT) ? POWER_W'(HEIGHT) : power_sel;
    assign at_last   = (cnt_q == size_q - 1'b1);
    assign busy      = (state != IDLE) || out_valid;

    // Next state plus the engine command strobes; at most one strobe per cycle
    always_comb begin
        next_state    = state;
        jreq_ready    = '0;
        in_ready      = '0;
        dct_address   = '0;
        dct_write     = 1'b0;
        dct_read      = 1'b0;
        dct_writedata = '0;
        load_fire     = 1'b0;
        read_fire     = 1'b0;
        case (state)
            IDLE: begin
                jreq_ready = grant;
                if (handshake) next_state = CFG_Q;
            end
            CFG_Q: begin
                dct_write     = 1'b1;
                dct_address   = ADDR_SETQ;
                dct_writedata = NBITS'(m_q);
                next_state    = CFG_SIZE;
            end
            CFG_SIZE: begin
                dct_write     = 1'b1;
                dct_address   = ADDR_START;
                dct_writedata = NBITS'(p_q);
                next_state    = LOAD;
            end
            LOAD: begin
                in_ready[owner] = 1'b1;
                if (in_valid[owner]) begin
                    dct_write     = 1'b1;
                    dct_address   = ADDR_DATA;
                    dct_writedata = in_data[owner];
                    load_fire     = 1'b1;
                    if (at_last) next_state = READ;
                end
            end
            READ: begin
                if (!out_valid || out_ready) begin
                    dct_read    = 1'b1;
                    dct_address = ADDR_W'(cnt_q);
                    if (dct_done) begin
                        read_fire = 1'b1;
                        if (at_last) next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Job context: owner and config latched at grant, shared sample/coefficient counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            owner  <= '0;
            m_q    <= '0;
            p_q    <= '0;
            size_q <= '0;
            cnt_q  <= '0;
        end else begin
            state <= next_state;
            if (handshake) begin
                owner  <= grant_idx;
                m_q    <= jreq_m[grant_idx];
                p_q    <= p_sat;
                size_q <= SIZE_W'(1) << p_sat;
                cnt_q  <= '0;
            end else if (load_fire) begin
                cnt_q <= at_last ? '0 : cnt_q + 1'b1;
            end else if (read_fire) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Single-entry output buffer, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_owner <= '0;
            out_last  <= 1'b0;
        end else if (read_fire) begin
            out_valid <= 1'b1;
            out_data  <= dct_readdata;
            out_index <= HEIGHT'(cnt_q);
            out_owner <= owner;
            out_last  <= at_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dct_job_scheduler.sv
// Randomized bench: requesters, a behavioural engine and a job-level reference model.
module tb_dct_job_scheduler;

    logic                clk;
    logic                reset_n;
    logic [1:0]          jreq_valid;
    logic [1:0][2:0]     jreq_power;
    logic [1:0][4:0]     jreq_m;
    logic [1:0]          jreq_ready;
    logic [1:0]          in_valid;
    logic [1:0][15:0]    in_data;
    logic [1:0]          in_ready;
    logic                out_valid;
    logic [15:0]         out_data;
    logic [5:0]          out_index;
    logic [0:0]          out_owner;
    logic                out_last;
    logic                out_ready;
    logic [7:0]          dct_address;
    logic                dct_write;
    logic                dct_read;
    logic [15:0]         dct_writedata;
    logic [15:0]         dct_readdata;
    logic                dct_done;
    logic                busy;

    dct_job_scheduler #(.MAX_SIZE(64), .NBITS(16), .NUM_REQ(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .jreq_valid    (jreq_valid),
        .jreq_power    (jreq_power),
        .jreq_m        (jreq_m),
        .jreq_ready    (jreq_ready),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_index     (out_index),
        .out_owner     (out_owner),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .dct_address   (dct_address),
        .dct_write     (dct_write),
        .dct_read      (dct_read),
        .dct_writedata (dct_writedata),
        .dct_readdata  (dct_readdata),
        .dct_done      (dct_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [5:0]  index;
        logic        owner;
        logic        last;
    } word_t;

    // Job records and requester queues
    logic [15:0] job_samp [64][64];
    int          job_req [64];
    int          job_pow [64];
    int          job_m   [64];
    int          njobs = 0;
    int          pend_q [2][$];
    word_t       exp_q [$];

    // Reference-model state
    int          model_last = 1;
    int          active = -1;
    int          feed_ptr = 0;
    bit          first_read = 0;
    bit          rst_seen = 0;
    bit          prev_hold = 0;
    logic [15:0] held_data;
    logic [5:0]  held_index;
    int          hold_cycles = 0;

    // Engine model
    logic [15:0] eng_mem [64];
    int          eng_cnt = 0;
    logic [4:0]  eng_m = '0;
    logic [2:0]  eng_p = '0;

    // Stimulus knobs
    int          gap_mode = 0;
    bit          ordy_rand = 0;
    bit          done_rand = 0;
    bit          req_drop = 0;
    bit          hold_armed = 0;
    int          hold_cnt = 0;
    bit          rst_armed = 0;
    int          cyc = 0;

    int          n_compared = 0;
    int          n_mismatched = 0;

    int          mon_idx;
    int          mon_j;
    logic [1:0]  mon_vec;
    word_t       mon_w;

    function automatic int psat(input int p);
        return (p > 6) ? 6 : p;
    endfunction

    function automatic int jobSize(input int j);
        return 1 << psat(job_pow[j]);
    endfunction

    // Mock engine transfer: depends on sample, index and both config registers
    function automatic logic [15:0] engineFn(input logic [15:0] s, input int k, input int m, input int p);
        logic [15:0] mix;
        mix = {3'(p), 5'(m), 8'h00};
        return (s + 16'(k * 257)) ^ mix;
    endfunction

    function automatic int rrWinner(input logic [1:0] v, input int last);
        for (int off = 1; off <= 2; off++) begin
            if (v[(last + off) % 2]) return (last + off) % 2;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic addJob(input int req, input int pow, input int m, input bit const_data);
        job_req[njobs] = req;
        job_pow[njobs] = pow;
        job_m[njobs]   = m;
        for (int k = 0; k < 64; k++) begin
            job_samp[njobs][k] = const_data ? 16'h0800 : 16'($urandom);
        end
        pend_q[req].push_back(njobs);
        njobs++;
    endtask

    // Granted job: queue every coefficient it must produce, in order
    task automatic startJob(input int j);
        word_t w;
        active     = j;
        feed_ptr   = 0;
        first_read = 1;
        for (int k = 0; k < jobSize(j); k++) begin
            w.data  = engineFn(job_samp[j][k], k, job_m[j], psat(job_pow[j]));
            w.index = 6'(k);
            w.owner = 1'(job_req[j]);
            w.last  = (k == jobSize(j) - 1);
            exp_q.push_back(w);
        end
    endtask

    always_comb begin
        dct_readdata = engineFn(eng_mem[dct_address[5:0]], int'(dct_address[5:0]), int'(eng_m), int'(eng_p));
    end

    // Drive one cycle of inputs just after the rising edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            jreq_valid[i] = (pend_q[i].size() > 0) && (!req_drop || $urandom_range(0, 3) != 0);
            if (pend_q[i].size() > 0) begin
                jreq_power[i] = 3'(job_pow[pend_q[i][0]]);
                jreq_m[i]     = 5'(job_m[pend_q[i][0]]);
            end
            in_valid[i] = 1'($urandom_range(0, 1));
            in_data[i]  = 16'($urandom);
        end
        if (active >= 0) begin
            if (feed_ptr < jobSize(active)) begin
                case (gap_mode)
                    1:       in_valid[job_req[active]] = cyc[0];
                    2:       in_valid[job_req[active]] = 1'($urandom_range(0, 1));
                    default: in_valid[job_req[active]] = 1'b1;
                endcase
                in_data[job_req[active]] = job_samp[active][feed_ptr];
            end else begin
                in_valid[job_req[active]] = 1'b0;
            end
        end
        if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
        end else if (hold_armed && out_valid && out_index == 6'd3) begin
            out_ready  = 1'b0;
            hold_cnt   = 4;
            hold_armed = 0;
        end else begin
            out_ready = ordy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        dct_done = done_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!reset_n) begin
            reset_n = 1'b1;
        end else if (rst_armed && active >= 0 && feed_ptr == 4) begin
            reset_n   = 1'b0;
            rst_armed = 0;
            in_valid  = '0;
        end
    endtask

    task automatic runUntilIdle(input int budget, input string name);
        int  n;
        bit  idle;
        n = 0;
        idle = 0;
        while (n < budget && !idle) begin
            applyStimulus();
            n++;
            idle = (n > 2) && pend_q[0].size() == 0 && pend_q[1].size() == 0 &&
                   exp_q.size() == 0 && !busy && reset_n && !rst_seen && !rst_armed;
        end
        checkOutput({"idle_", name}, idle, 1);
        if (!idle) begin
            pend_q[0].delete();
            pend_q[1].delete();
            exp_q.delete();
        end
        jreq_valid = '0;
        $display("[TB] %s done after %0d cycles", name, n);
    endtask

    // Monitor, engine model and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset_n) begin
            rst_seen   = 1;
            exp_q.delete();
            active     = -1;
            model_last = 1;
            prev_hold  = 0;
        end else begin
            if (rst_seen) begin
                rst_seen = 0;
                checkOutput("rst_out_valid", out_valid, 0);
                checkOutput("rst_out_data", out_data, 0);
                checkOutput("rst_out_meta", {out_index, out_owner, out_last}, 0);
                checkOutput("rst_cmd", {dct_write, dct_read, dct_address, dct_writedata}, 0);
                checkOutput("rst_ready", {jreq_ready, in_ready}, 0);
                checkOutput("rst_busy", busy, 0);
            end

            checkOutput("one_strobe", dct_write & dct_read, 0);

            mon_idx = rrWinner(jreq_valid, model_last);
            mon_vec = (mon_idx >= 0) ? 2'(2'b01 << mon_idx) : 2'b00;
            if (jreq_ready != 2'b00) begin
                checkOutput("grant", jreq_ready, mon_vec);
                if (mon_idx >= 0 && pend_q[mon_idx].size() > 0) begin
                    mon_j = pend_q[mon_idx].pop_front();
                    model_last = mon_idx;
                    startJob(mon_j);
                end
            end

            if (in_ready != 2'b00) begin
                checkOutput("no_grant_in_load", jreq_ready, 0);
                checkOutput("in_ready_owner", in_ready,
                            (active >= 0) ? 2'(2'b01 << job_req[active]) : 2'b00);
                if (active >= 0 && in_ready[job_req[active]]) begin
                    checkOutput("wr_on_valid", dct_write, in_valid[job_req[active]]);
                    if (in_valid[job_req[active]]) feed_ptr++;
                end
            end

            if (dct_write) begin
                if (active < 0) begin
                    checkOutput("wr_without_job", dct_write, 0);
                end else begin
                    case (dct_address)
                        8'd2: begin
                            checkOutput("cfg_m", dct_writedata, job_m[active]);
                            eng_m = dct_writedata[4:0];
                        end
                        8'd0: begin
                            checkOutput("cfg_p", dct_writedata, psat(job_pow[active]));
                            eng_p   = dct_writedata[2:0];
                            eng_cnt = 0;
                        end
                        8'd1: begin
                            checkOutput("wr_in_range", eng_cnt < jobSize(active), 1);
                            if (eng_cnt < 64) begin
                                checkOutput("wr_data", dct_writedata, job_samp[active][eng_cnt]);
                                eng_mem[eng_cnt] = dct_writedata;
                            end
                            eng_cnt++;
                        end
                        default: checkOutput("wr_addr", dct_address, 1);
                    endcase
                end
            end

            if (dct_read && first_read) begin
                first_read = 0;
                checkOutput("wr_count", eng_cnt, (active >= 0) ? jobSize(active) : 0);
            end

            if (out_valid && !out_ready) begin
                hold_cycles++;
                checkOutput("read_hold", dct_read, 0);
                if (prev_hold) begin
                    checkOutput("hold_data", out_data, held_data);
                    checkOutput("hold_index", out_index, held_index);
                end
                prev_hold  = 1;
                held_data  = out_data;
                held_index = out_index;
            end else begin
                prev_hold = 0;
            end

            if (out_valid && out_ready) begin
                checkOutput("out_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_w = exp_q.pop_front();
                    checkOutput("out_data", out_data, mon_w.data);
                    checkOutput("out_index", out_index, mon_w.index);
                    checkOutput("out_owner", out_owner, mon_w.owner);
                    checkOutput("out_last", out_last, mon_w.last);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 64; k++) eng_mem[k] = '0;
        reset_n    = 1'b0;
        jreq_valid = '0;
        jreq_power = '0;
        jreq_m     = '0;
        in_valid   = '0;
        in_data    = '0;
        out_ready  = 1'b1;
        dct_done   = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        $display("[TB] single 8-point job on requester 0");
        addJob(0, 3, 0, 1);
        runUntilIdle(200, "single");

        $display("[TB] both requesters, three jobs each");
        for (int n = 0; n < 3; n++) begin
            addJob(0, 3, $urandom_range(0, 31), 0);
            addJob(1, 3, $urandom_range(0, 31), 0);
        end
        runUntilIdle(1000, "alternate");

        $display("[TB] consumer stall at k=3");
        hold_cycles = 0;
        hold_armed  = 1;
        addJob(0, 3, 5, 0);
        runUntilIdle(200, "hold");
        checkOutput("hold_cycles", hold_cycles, 5);

        $display("[TB] gapped input, same samples as the first job");
        gap_mode = 1;
        addJob(0, 3, 0, 1);
        runUntilIdle(200, "gaps");
        gap_mode = 0;

        $display("[TB] saturated power and a one-sample job");
        addJob(1, 7, 9, 0);
        addJob(0, 0, 3, 0);
        runUntilIdle(600, "saturate");

        $display("[TB] reset in the middle of LOAD");
        rst_armed = 1;
        addJob(0, 3, 2, 0);
        runUntilIdle(200, "reset");
        addJob(1, 3, 4, 0);
        runUntilIdle(200, "after_reset");

        $display("[TB] randomized traffic with stalls and gaps");
        gap_mode  = 2;
        ordy_rand = 1;
        done_rand = 1;
        req_drop  = 1;
        for (int n = 0; n < 10; n++) begin
            addJob($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 31), 0);
        end
        runUntilIdle(8000, "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
